wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between two sources:
//  - the in-order pipeline write-back (mem/wb)
//  - a long-latency unit (mul/div, late load) that returns results out of band.

---
 rtl/wb_port_arbiter_pkg.sv | 24 ++
 rtl/wb_result_fifo.sv | 57 +++++
 rtl/wb_port_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// wb_port_arbiter_pkg : shared widths, write-request struct and arbiter states
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_port_arbiter_pkg;

  localparam int D_SIZE        = 32;
  localparam int ADDR_LINE_REG = 5;

  typedef struct packed {
    logic [D_SIZE-1:0]        data;
    logic [ADDR_LINE_REG-1:0] addr;
  } wb_req_t;

  typedef enum logic [0:0] {
    WBARB_NORMAL = 1'b0,
    WBARB_DRAIN  = 1'b1
  } wbarb_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_result_fifo.sv
// ============================================================================
// wb_result_fifo : synchronous FIFO of long-latency write-back requests
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output logic    one_left_o,
  output wb_req_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] w_fill;
  wb_req_t        mem_q [DEPTH];

  assign wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign w_fill     = wr_ptr_q - rd_ptr_q;
  assign one_left_o = (w_fill == (PTR_W+1)'(1));
  assign head_o     = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// wb_port_arbiter : shares the RF write port between pipeline WB and mc results
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_valid_f_mem,
  input  logic [D_SIZE-1:0]        wb_data_f_mem,
  input  logic [ADDR_LINE_REG-1:0] wb_addr_f_mem,
  input  logic                     mc_valid,
  input  logic [D_SIZE-1:0]        mc_data,
  input  logic [ADDR_LINE_REG-1:0] mc_addr,
  output logic                     mc_ready,
  output logic                     stall_f_wb,
  output logic                     reg_we_f_wb_id,
  output logic [D_SIZE-1:0]        reg_data_f_wb_id,
  output logic [ADDR_LINE_REG-1:0] reg_addr_f_wb_id
);

  localparam int             CNT_W       = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

  wbarb_state_e             state_q, state_d;
  logic [CNT_W-1:0]         starve_cnt_q, starve_cnt_d;
  logic                     we_q;
  logic [D_SIZE-1:0]        data_q;
  logic [ADDR_LINE_REG-1:0] addr_q;

  logic    w_full, w_empty, w_one_left, w_push, w_pop, w_grant;
  wb_req_t w_head, w_mc_req, w_pipe_req, w_grant_req;

  assign w_mc_req   = '{data: mc_data, addr: mc_addr};
  assign w_pipe_req = '{data: wb_data_f_mem, addr: wb_addr_f_mem};
  assign mc_ready   = !w_full;
  assign w_push     = mc_valid && !w_full;

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (w_mc_req),
    .pop_i       (w_pop),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .one_left_o  (w_one_left),
    .head_o      (w_head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WBARB_NORMAL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WBARB_NORMAL: if (!w_empty && !w_pop && (starve_cnt_q == STARVE_LAST)) state_d = WBARB_DRAIN;
      WBARB_DRAIN:  if (w_pop && w_one_left && !w_push) state_d = WBARB_NORMAL;
      default:      state_d = WBARB_NORMAL;
    endcase
  end

  // Grant selection: pipeline has priority in NORMAL and is locked out in DRAIN.
  always_comb begin
    w_grant     = 1'b0;
    w_pop       = 1'b0;
    w_grant_req = w_pipe_req;
    unique case (state_q)
      WBARB_NORMAL: begin
        if (wb_valid_f_mem) begin
          w_grant = 1'b1;
        end else if (!w_empty) begin
          w_grant     = 1'b1;
          w_pop       = 1'b1;
          w_grant_req = w_head;
        end
      end
      WBARB_DRAIN: begin
        if (!w_empty) begin
          w_grant     = 1'b1;
          w_pop       = 1'b1;
          w_grant_req = w_head;
        end
      end
      default: ;
    endcase
  end

  assign stall_f_wb = (state_q == WBARB_DRAIN);

  always_comb begin
    if ((state_q == WBARB_DRAIN) || (state_d == WBARB_DRAIN) || w_empty || w_pop)
      starve_cnt_d = '0;
    else
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      we_q         <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      we_q         <= w_grant && (w_grant_req.addr != '0);
      if (w_grant) begin
        data_q <= w_grant_req.data;
        addr_q <= w_grant_req.addr;
      end
    end
  end

  assign reg_we_f_wb_id   = we_q;
  assign reg_data_f_wb_id = data_q;
  assign reg_addr_f_wb_id = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// tb_wb_port_arbiter : directed self-checking bench for wb_port_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic                     clk;
  logic                     rst;
  logic                     wb_valid_f_mem;
  logic [D_SIZE-1:0]        wb_data_f_mem;
  logic [ADDR_LINE_REG-1:0] wb_addr_f_mem;
  logic                     mc_valid;
  logic [D_SIZE-1:0]        mc_data;
  logic [ADDR_LINE_REG-1:0] mc_addr;
  logic                     mc_ready;
  logic                     stall_f_wb;
  logic                     reg_we_f_wb_id;
  logic [D_SIZE-1:0]        reg_data_f_wb_id;
  logic [ADDR_LINE_REG-1:0] reg_addr_f_wb_id;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb_valid_f_mem   (wb_valid_f_mem),
    .wb_data_f_mem    (wb_data_f_mem),
    .wb_addr_f_mem    (wb_addr_f_mem),
    .mc_valid         (mc_valid),
    .mc_data          (mc_data),
    .mc_addr          (mc_addr),
    .mc_ready         (mc_ready),
    .stall_f_wb       (stall_f_wb),
    .reg_we_f_wb_id   (reg_we_f_wb_id),
    .reg_data_f_wb_id (reg_data_f_wb_id),
    .reg_addr_f_wb_id (reg_addr_f_wb_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_write(input string tag, input logic [4:0] addr, input logic [31:0] data);
    check({tag, " we"},   32'(reg_we_f_wb_id),   32'd1);
    check({tag, " addr"}, 32'(reg_addr_f_wb_id), 32'(addr));
    check({tag, " data"}, reg_data_f_wb_id,      data);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " we"},    32'(reg_we_f_wb_id),   32'd0);
    check({tag, " data"},  reg_data_f_wb_id,      32'd0);
    check({tag, " addr"},  32'(reg_addr_f_wb_id), 32'd0);
    check({tag, " stall"}, 32'(stall_f_wb),       32'd0);
    check({tag, " ready"}, 32'(mc_ready),         32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    wb_valid_f_mem = 1'b0;
    wb_data_f_mem  = '0;
    wb_addr_f_mem  = '0;
    mc_valid       = 1'b0;
    mc_data        = '0;
    mc_addr        = '0;

    // Power-on reset
    #2;
    check_idle_outputs("por");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("post_por");

    // Pipeline-only write
    wb_valid_f_mem = 1'b1; wb_addr_f_mem = 5'd5; wb_data_f_mem = 32'hA5;
    tick();
    check_write("pipe", 5'd5, 32'hA5);
    check("pipe stall", 32'(stall_f_wb), 32'd0);
    wb_valid_f_mem = 1'b0;
    tick();
    check("pipe idle we", 32'(reg_we_f_wb_id), 32'd0);

    // Idle-slot drain of an mc result
    mc_valid = 1'b1; mc_addr = 5'd3; mc_data = 32'h11;
    tick();
    check("idle push we", 32'(reg_we_f_wb_id), 32'd0);
    mc_valid = 1'b0;
    tick();
    check_write("idle pop", 5'd3, 32'h11);
    tick();
    check("idle after we", 32'(reg_we_f_wb_id), 32'd0);

    // Starvation: one mc entry while the pipeline writes every cycle
    wb_valid_f_mem = 1'b1; wb_addr_f_mem = 5'd7; wb_data_f_mem = 32'h70;
    mc_valid = 1'b1; mc_addr = 5'd9; mc_data = 32'h99;
    tick();
    mc_valid = 1'b0;
    check_write("starve c1", 5'd7, 32'h70);
    check("starve c1 stall", 32'(stall_f_wb), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("starve pre stall", 32'(stall_f_wb), 32'd0);
    end
    tick();
    check("starve c5 stall", 32'(stall_f_wb), 32'd1);
    check_write("starve c5", 5'd7, 32'h70);
    tick();
    check("starve c6 stall", 32'(stall_f_wb), 32'd0);
    check_write("starve mc", 5'd9, 32'h99);
    tick();
    check_write("starve held pipe", 5'd7, 32'h70);
    wb_valid_f_mem = 1'b0;
    tick();
    check("starve idle we", 32'(reg_we_f_wb_id), 32'd0);

    // Full FIFO backpressure
    wb_valid_f_mem = 1'b1; wb_addr_f_mem = 5'd4; wb_data_f_mem = 32'h44;
    mc_valid = 1'b1; mc_addr = 5'd10; mc_data = 32'hA0;
    tick();
    check("full e1 ready", 32'(mc_ready), 32'd1);
    mc_addr = 5'd11; mc_data = 32'hB0;
    tick();
    check("full e2 ready", 32'(mc_ready), 32'd0);
    mc_addr = 5'd12; mc_data = 32'hC0;
    for (int i = 3; i <= 4; i++) begin
      tick();
      check("full held ready", 32'(mc_ready), 32'd0);
      check("full held stall", 32'(stall_f_wb), 32'd0);
    end
    tick();
    check("full e5 stall", 32'(stall_f_wb), 32'd1);
    check("full e5 ready", 32'(mc_ready), 32'd0);
    tick();
    check_write("full pop A", 5'd10, 32'hA0);
    check("full e6 ready", 32'(mc_ready), 32'd1);
    check("full e6 stall", 32'(stall_f_wb), 32'd1);
    tick();
    check_write("full pop B", 5'd11, 32'hB0);
    check("full e7 stall", 32'(stall_f_wb), 32'd1);
    mc_valid = 1'b0;
    tick();
    check_write("full pop C", 5'd12, 32'hC0);
    check("full e8 stall", 32'(stall_f_wb), 32'd0);
    tick();
    check_write("full held pipe", 5'd4, 32'h44);
    wb_valid_f_mem = 1'b0;
    tick();
    check("full idle we", 32'(reg_we_f_wb_id), 32'd0);

    // r0 write is consumed but never written
    wb_valid_f_mem = 1'b1; wb_addr_f_mem = 5'd0; wb_data_f_mem = 32'hFF;
    tick();
    check("r0 we", 32'(reg_we_f_wb_id), 32'd0);
    check("r0 stall", 32'(stall_f_wb), 32'd0);
    check("r0 ready", 32'(mc_ready), 32'd1);
    wb_valid_f_mem = 1'b0;
    tick();
    check("r0 after we", 32'(reg_we_f_wb_id), 32'd0);

    // Reset mid-stream with two buffered results
    wb_valid_f_mem = 1'b1; wb_addr_f_mem = 5'd6; wb_data_f_mem = 32'h66;
    mc_valid = 1'b1; mc_addr = 5'd1; mc_data = 32'h10;
    tick();
    mc_addr = 5'd2; mc_data = 32'h20;
    tick();
    check("mid full ready", 32'(mc_ready), 32'd0);
    check_write("mid pipe", 5'd6, 32'h66);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("mid rst");
    wb_valid_f_mem = 1'b0;
    mc_valid       = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid no stale we", 32'(reg_we_f_wb_id), 32'd0);
      check("mid no stall", 32'(stall_f_wb), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
